mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read block RAM (32-bit words, 1-cycle read latency, per-byte write enables) between the core's instruction-fetch port and its load/store port.
- Arbitrates one access per cycle, generates byte-lane enables and write-data shifting, and right-aligns and zero-extends load data.
- Sits between core and the RAM array in top, replacing ad hoc dual-address indexing.

Parameters:
- ADDR_W, 12, RAM word-address width; RAM depth = 2^ADDR_W words.
- STARVE_LIMIT, 3, consecutive cycles fetch may be denied before it is forced a grant; range 1..15.

Ports:
- clk24  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_data  out  32  fetched word.
- if_rsp_err  out  1  fetch misaligned (MISALIGN_ERR_EN only, else 0).
- d_req_valid  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_req_ready  out  1  data request accepted this cycle.
- d_rsp_valid  out  1  load data or store ack valid.
- d_rsp_data  out  32  load data, right-aligned, zero-extended; 0 for stores.
- d_rsp_err  out  1  data misaligned (MISALIGN_ERR_EN only, else 0).
- ram_addr  out  ADDR_W  RAM word address.
- ram_we  out  4  byte write enables.
- ram_wdata  out  32  lane-shifted write data.
- ram_rdata  in  32  RAM read data, one cycle after ram_addr.

Behaviour:
- Grant logic is combinational from the request inputs. At most one grant per cycle; ready = grant. Requesters must hold valid/address until ready.
- Priority:
  - Data wins, except when starve_cnt == STARVE_LIMIT and fetch is valid; then fetch wins that cycle.
  - starve_cnt increments, saturating, each cycle fetch is valid and not granted. It clears to 0 on a fetch grant or when fetch is not valid.
- RAM drive:
  - ram_addr = granted_addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap.
  - With no grant, ram_addr = if_addr index and ram_we = 0.
- Store lanes (off = d_addr[1:0]):
  - byte: ram_we = 0001 << off.
  - half: ram_we = 0011 << off[1]*2.
  - word: ram_we = 1111.
  - ram_wdata = d_wdata << (lane offset * 8).
- Misalignment without MISALIGN_ERR_EN:
  - half ignores addr[0]; word ignores addr[1:0].
  - fetch ignores if_addr[1:0].
- Responses:
  - Exactly one cycle after a grant, the matching rsp_valid pulses for one cycle. Responses cannot be stalled.
  - Read data is ram_rdata >> (registered offset * 8), masked to 8/16/32 bits per registered size.
  - Store ack: d_rsp_valid = 1, d_rsp_data = 0. Read-after-write to the same word on back-to-back grants returns the new data; the RAM is write-first.
- Back-to-back: a new grant is permitted every cycle, including the cycle a response is presented.
- Reset:
  - starve_cnt = 0; if_rsp_valid = d_rsp_valid = 0; if_rsp_err = d_rsp_err = 0; rsp data = 0.
  - While reset is high: no grants, ram_we = 0.
  - A response pending at reset is dropped; no rsp_valid in the cycle after reset deasserts.

Optional Feature:
- MISALIGN_ERR_EN.
- Defined:
  - A misaligned request (half with addr[0] = 1, word/size 3 with addr[1:0] != 0, fetch with if_addr[1:0] != 0) is still granted normally, with ram_we forced to 0.
  - Next cycle: rsp_valid = 1, rsp_err = 1, rsp_data = 0.
- Undefined: err outputs tied to 0; low bits masked as above.

Test Plan:
- Fetch only, if_addr = 0x8, RAM[2] = 0xDEADBEEF -> if_req_ready same cycle; next cycle if_rsp_valid = 1, if_rsp_data = 0xDEADBEEF.
- Store byte d_addr = 0x7, d_wdata = 0xAB -> ram_we = 1000, ram_wdata[31:24] = 0xAB; load half from 0x6 -> d_rsp_data = 0x0000ABxx with other bytes preserved.
- Fetch and data valid continuously for 10 cycles, STARVE_LIMIT = 3 -> data granted cycles 0-2, fetch granted cycle 3, data cycles 4-6, fetch cycle 7; one grant per cycle always.
- Load word from 0x4002 with ADDR_W = 12: without MISALIGN_ERR_EN, reads word index 0 (wrap, low bits masked); with it, d_rsp_err = 1, d_rsp_data = 0, and RAM is unchanged.
- Assert reset in the cycle after a load grant -> no d_rsp_valid after reset; starve_cnt = 0; first grant after release follows normal priority.
- Store word 0x12345678 to 0x10, then load 0x10 the next cycle -> d_rsp_data = 0x12345678.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Core-side request/response and RAM-side bus of mem_arbiter.
// slave = arbiter view, master = core + RAM view.
interface mem_arbiter_if #(parameter int ADDR_W = 12);
  logic              if_req_valid;
  logic [31:0]       if_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              if_rsp_err;

  logic              d_req_valid;
  logic              d_we;
  logic [1:0]        d_size;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              d_rsp_err;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_we, d_size, d_addr, d_wdata, ram_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
           d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_we, d_size, d_addr, d_wdata, ram_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
           d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
           ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, one grant per cycle.
// Optional MISALIGN_ERR_EN: misaligned requests are granted without writing and answered with err.
module mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 3
) (
  input logic           clk24,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  logic [3:0]  starve_cnt;
  logic        f_force, d_gnt, f_gnt;
  logic [1:0]  d_lane;
  logic [3:0]  d_be;
  logic        d_mis, f_mis;

  logic        f_rsp_q, d_rsp_q, d_we_q, f_err_q, d_err_q;
  logic [1:0]  d_size_q, d_lane_q;
  logic [31:0] rd_sh, rd_mask;

  // Data normally wins; a fetch that has waited STARVE_LIMIT cycles takes the slot.
  always_comb begin
    f_force = bus.if_req_valid && (starve_cnt == 4'(STARVE_LIMIT));
    d_gnt   = !reset && bus.d_req_valid && !f_force;
    f_gnt   = !reset && bus.if_req_valid && !d_gnt;
  end

  always_comb begin
    d_lane = 2'd0;
    d_be   = 4'b1111;
    unique case (bus.d_size)
      2'd0: begin
        d_lane = bus.d_addr[1:0];
        d_be   = 4'b0001 << bus.d_addr[1:0];
      end
      2'd1: begin
        d_lane = {bus.d_addr[1], 1'b0};
        d_be   = bus.d_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        d_lane = 2'd0;
        d_be   = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_ERR_EN
  assign d_mis = ((bus.d_size == 2'd1) && bus.d_addr[0]) ||
                 (bus.d_size[1] && (bus.d_addr[1:0] != 2'b00));
  assign f_mis = (bus.if_addr[1:0] != 2'b00);
`else
  assign d_mis = 1'b0;
  assign f_mis = 1'b0;
`endif

  assign bus.d_req_ready  = d_gnt;
  assign bus.if_req_ready = f_gnt;
  assign bus.ram_addr     = d_gnt ? bus.d_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
  assign bus.ram_we       = (d_gnt && bus.d_we && !d_mis) ? d_be : 4'b0000;
  assign bus.ram_wdata    = bus.d_wdata << {d_lane, 3'b000};

  always_ff @(posedge clk24) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (f_gnt || !bus.if_req_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      f_rsp_q  <= 1'b0;
      d_rsp_q  <= 1'b0;
      f_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      d_we_q   <= 1'b0;
      d_size_q <= 2'd0;
      d_lane_q <= 2'd0;
    end else begin
      f_rsp_q <= f_gnt;
      d_rsp_q <= d_gnt;
      f_err_q <= f_gnt && f_mis;
      d_err_q <= d_gnt && d_mis;
      if (d_gnt) begin
        d_we_q   <= bus.d_we;
        d_size_q <= bus.d_size;
        d_lane_q <= d_lane;
      end
    end
  end

  // Load data comes straight off the RAM read port, aligned and zero-extended.
  always_comb begin
    rd_sh = bus.ram_rdata >> {d_lane_q, 3'b000};
    unique case (d_size_q)
      2'd0:    rd_mask = {24'h0, rd_sh[7:0]};
      2'd1:    rd_mask = {16'h0, rd_sh[15:0]};
      default: rd_mask = rd_sh;
    endcase
  end

  // Outputs are masked by reset so a response in flight at reset is never presented.
  assign bus.if_rsp_valid = f_rsp_q && !reset;
  assign bus.if_rsp_err   = f_err_q && !reset;
  assign bus.if_rsp_data  = (bus.if_rsp_valid && !f_err_q) ? bus.ram_rdata : 32'h0;
  assign bus.d_rsp_valid  = d_rsp_q && !reset;
  assign bus.d_rsp_err    = d_err_q && !reset;
  assign bus.d_rsp_data   = (bus.d_rsp_valid && !d_we_q && !d_err_q) ? rd_mask : 32'h0;

  logic unused_addr;
  assign unused_addr = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0], bus.d_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a word/byte-level reference memory model.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int SL = 3;
  localparam int DEPTH = 1 << AW;

  logic clk24 = 1'b0;
  logic reset = 1'b1;
  logic ram_clr = 1'b1;
  always #5 clk24 = ~clk24;

  mem_arbiter_if #(.ADDR_W(AW)) bus();
  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (.clk24(clk24), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-first synchronous RAM.
  logic [31:0] ram [0:DEPTH-1];
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk24) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      ram[bus.ram_addr] <= merge(ram[bus.ram_addr], bus.ram_we, bus.ram_wdata);
      bus.ram_rdata     <= merge(ram[bus.ram_addr], bus.ram_we, bus.ram_wdata);
    end
  end

  // Reference model: byte-addressed memory contents, fetch wait count, expected next responses.
  logic [31:0] m_ref [0:DEPTH-1];
  initial begin
    int m_starve;
    logic pf_v, pf_e, pd_v, pd_e;
    logic [31:0] pf_d, pd_d;
    logic fv, dv, gd, gf, mis_d, mis_f;
    int nb, lane, alow;
    logic [AW-1:0] di, fi;
    logic [3:0] exp_we;
    m_starve = 0;
    pf_v = 0; pf_e = 0; pd_v = 0; pd_e = 0; pf_d = 0; pd_d = 0;
    forever begin
      @(negedge clk24);
      if (ram_clr) for (int i = 0; i < DEPTH; i++) m_ref[i] = '0;

      chk("if_rsp_valid", {31'h0, bus.if_rsp_valid}, {31'h0, pf_v && !reset});
      chk("if_rsp_err",   {31'h0, bus.if_rsp_err},   {31'h0, pf_e && !reset});
      chk("if_rsp_data",  bus.if_rsp_data,           reset ? 32'h0 : pf_d);
      chk("d_rsp_valid",  {31'h0, bus.d_rsp_valid},  {31'h0, pd_v && !reset});
      chk("d_rsp_err",    {31'h0, bus.d_rsp_err},    {31'h0, pd_e && !reset});
      chk("d_rsp_data",   bus.d_rsp_data,            reset ? 32'h0 : pd_d);

      fv = bus.if_req_valid;
      dv = bus.d_req_valid;
      gd = !reset && dv && !(fv && m_starve == SL);
      gf = !reset && fv && !gd;
      chk("d_req_ready",  {31'h0, bus.d_req_ready},  {31'h0, gd});
      chk("if_req_ready", {31'h0, bus.if_req_ready}, {31'h0, gf});

      di = bus.d_addr[AW+1:2];
      fi = bus.if_addr[AW+1:2];
      chk("ram_addr", {{(32-AW){1'b0}}, bus.ram_addr}, {{(32-AW){1'b0}}, gd ? di : fi});

      nb   = (bus.d_size == 2'd0) ? 1 : (bus.d_size == 2'd1) ? 2 : 4;
      alow = int'(bus.d_addr[1:0]);
      lane = (nb == 1) ? alow : (nb == 2) ? (alow / 2) * 2 : 0;
`ifdef MISALIGN_ERR_EN
      mis_d = (alow % nb) != 0;
      mis_f = bus.if_addr[1:0] != 2'b00;
`else
      mis_d = 1'b0;
      mis_f = 1'b0;
`endif
      exp_we = (gd && bus.d_we && !mis_d) ? 4'(((1 << nb) - 1) << lane) : 4'b0000;
      chk("ram_we", {28'h0, bus.ram_we}, {28'h0, exp_we});
      if (exp_we != 4'b0000) chk("ram_wdata", bus.ram_wdata, bus.d_wdata << (lane * 8));

      pf_v = gf;
      pf_e = gf && mis_f;
      pf_d = (gf && !mis_f) ? m_ref[fi] : 32'h0;
      pd_v = gd;
      pd_e = gd && mis_d;
      pd_d = 32'h0;
      if (gd && !mis_d) begin
        if (bus.d_we) begin
          for (int b = 0; b < nb; b++) m_ref[di][(lane + b)*8 +: 8] = bus.d_wdata[b*8 +: 8];
        end else begin
          pd_d = m_ref[di] >> (lane * 8);
          if (nb < 4) pd_d = pd_d & ((32'h1 << (nb * 8)) - 32'h1);
        end
      end

      if (reset) m_starve = 0;
      else if (fv && !gf) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else m_starve = 0;
    end
  end

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic idle();
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
  endtask

  task automatic drv_d(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.d_req_valid = 1'b1;
    bus.d_we        = we;
    bus.d_size      = sz;
    bus.d_addr      = a;
    bus.d_wdata     = wd;
  endtask

  task automatic drv_f(input logic [31:0] a);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = a;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_C000);
    return a;
  endfunction

  initial begin
    logic [9:0] fg, dg;
    logic dgr, fgr;
    logic [7:0] top_byte;
    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset: requests held valid must not be granted.
    tick(); tick();
    drv_f(32'h8);
    drv_d(1'b1, 2'd2, 32'h8, 32'h5555_5555);
    @(negedge clk24);
    chk("rst_d_ready", {31'h0, bus.d_req_ready}, 32'h0);
    chk("rst_f_ready", {31'h0, bus.if_req_ready}, 32'h0);
    chk("rst_ram_we", {28'h0, bus.ram_we}, 32'h0);
    tick();
    idle(); reset = 1'b0; ram_clr = 1'b0;
    @(negedge clk24);
    chk("post_rst_d_rsp", {31'h0, bus.d_rsp_valid}, 32'h0);
    chk("post_rst_f_rsp", {31'h0, bus.if_rsp_valid}, 32'h0);

    // Fetch of a preloaded word.
    tick();
    drv_d(1'b1, 2'd2, 32'h8, 32'hDEAD_BEEF);
    tick(); idle();
    drv_f(32'h8);
    @(negedge clk24);
    chk("fetch_ready", {31'h0, bus.if_req_ready}, 32'h1);
    tick(); idle();
    @(negedge clk24);
    chk("fetch_rsp_valid", {31'h0, bus.if_rsp_valid}, 32'h1);
    chk("fetch_rsp_data", bus.if_rsp_data, 32'hDEAD_BEEF);

    // Byte store into lane 3, then half load of the upper half.
    tick();
    drv_d(1'b1, 2'd2, 32'h4, 32'h1122_3344);
    tick();
    drv_d(1'b1, 2'd0, 32'h7, 32'h0000_00AB);
    @(negedge clk24);
    top_byte = bus.ram_wdata[31:24];
    chk("sb_ram_we", {28'h0, bus.ram_we}, 32'h8);
    chk("sb_wdata_top", {24'h0, top_byte}, 32'hAB);
    tick();
    drv_d(1'b0, 2'd1, 32'h6, 32'h0);
    tick(); idle();
    @(negedge clk24);
    chk("lh_data", bus.d_rsp_data, 32'h0000_AB22);

    // Contention: fetch forced in every fourth cycle.
    tick(); idle();
    tick();
    drv_f(32'h0);
    for (int i = 0; i < 10; i++) begin
      drv_d(1'b0, 2'd2, 32'h20, 32'h0);
      @(negedge clk24);
      fg[i] = bus.if_req_ready;
      dg[i] = bus.d_req_ready;
      tick();
    end
    idle();
    chk("starve_fetch_pat", {22'h0, fg}, 32'b0010001000);
    chk("starve_data_pat",  {22'h0, dg}, 32'b1101110111);

    // Wrapped, misaligned word load.
    tick();
    drv_d(1'b1, 2'd2, 32'h0, 32'hCAFE_F00D);
    tick();
    drv_d(1'b0, 2'd2, 32'h4002, 32'h0);
    tick(); idle();
    @(negedge clk24);
`ifdef MISALIGN_ERR_EN
    chk("wrap_err", {31'h0, bus.d_rsp_err}, 32'h1);
    chk("wrap_data", bus.d_rsp_data, 32'h0);
`else
    chk("wrap_err", {31'h0, bus.d_rsp_err}, 32'h0);
    chk("wrap_data", bus.d_rsp_data, 32'hCAFE_F00D);
`endif

    // Reset right after a load grant drops its response.
    tick();
    drv_d(1'b0, 2'd2, 32'h4, 32'h0);
    tick(); idle(); reset = 1'b1;
    @(negedge clk24);
    chk("drop_in_rst", {31'h0, bus.d_rsp_valid}, 32'h0);
    tick(); reset = 1'b0;
    @(negedge clk24);
    chk("drop_after_rst", {31'h0, bus.d_rsp_valid}, 32'h0);
    tick();
    drv_f(32'h8);
    drv_d(1'b0, 2'd2, 32'h8, 32'h0);
    @(negedge clk24);
    chk("post_rst_prio_d", {31'h0, bus.d_req_ready}, 32'h1);
    chk("post_rst_prio_f", {31'h0, bus.if_req_ready}, 32'h0);
    tick(); idle();

    // Back-to-back store then load of the same word.
    tick();
    drv_d(1'b1, 2'd2, 32'h10, 32'h1234_5678);
    tick();
    drv_d(1'b0, 2'd2, 32'h10, 32'h0);
    tick(); idle();
    @(negedge clk24);
    chk("raw_data", bus.d_rsp_data, 32'h1234_5678);
    tick();

    // Randomized traffic; requests are held until accepted.
    dgr = 1'b1; fgr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.d_req_valid || dgr) begin
        if ($urandom_range(0, 3) != 0)
          drv_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_addr(), $urandom);
        else
          bus.d_req_valid = 1'b0;
      end
      if (!bus.if_req_valid || fgr) begin
        if ($urandom_range(0, 2) != 0) drv_f(rnd_addr());
        else bus.if_req_valid = 1'b0;
      end
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk24);
      dgr = bus.d_req_ready;
      fgr = bus.if_req_ready;
      tick();
    end
    idle(); reset = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
